// File: rtl/pmp_csr_regs.sv
// rtl/pmp_csr_regs.sv - RV32 PMP pmpcfg/pmpaddr CSR file with WARL and lock rules
//
// Purpose: decodes CSR reads/writes to pmpcfg0..(N/4-1) (0x3A0+K) and
// pmpaddr0..(N-1) (0x3B0+I), stores the per-entry state and taps it straight
// out to the per-entry address checkers and the priority stage.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   csr_we / csr_re     one-cycle write / read strobes
//   csr_addr, csr_wdata CSR address and write data
//   csr_rdata/rvalid    registered read data, valid one cycle after csr_re
//   csr_illegal         one-cycle pulse after an access to an unmapped address
//   pmp_update          one-cycle pulse after a write that changed stored state
//   pmp_addr_o          pmpaddr[i] at [32i+31:32i]
//   pmp_addr_prev_o     pmpaddr[i-1] at [32i+31:32i]; entry 0 slice is 0
//   pmp_a_o             cfg[i].A at [2i+1:2i]
//   pmp_r/w/x/l_o       per-entry permission and lock bits

module pmp_csr_regs #(
    parameter int N_ENTRIES = 16,
    parameter int XLEN      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      csr_we,
    input  logic                      csr_re,
    input  logic [11:0]               csr_addr,
    input  logic [XLEN-1:0]           csr_wdata,
    output logic [XLEN-1:0]           csr_rdata,
    output logic                      csr_rvalid,
    output logic                      csr_illegal,
    output logic                      pmp_update,
    output logic [XLEN*N_ENTRIES-1:0] pmp_addr_o,
    output logic [XLEN*N_ENTRIES-1:0] pmp_addr_prev_o,
    output logic [2*N_ENTRIES-1:0]    pmp_a_o,
    output logic [N_ENTRIES-1:0]      pmp_r_o,
    output logic [N_ENTRIES-1:0]      pmp_w_o,
    output logic [N_ENTRIES-1:0]      pmp_x_o,
    output logic [N_ENTRIES-1:0]      pmp_l_o
);

    localparam logic [1:0] A_TOR = 2'b01;

    logic [7:0]      cfg_q  [N_ENTRIES];
    logic [7:0]      cfg_d  [N_ENTRIES];
    logic [XLEN-1:0] addr_q [N_ENTRIES];
    logic [XLEN-1:0] addr_d [N_ENTRIES];

    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            rvalid_q, illegal_q, update_q, changed;

    logic [3:0] idx;
    logic       is_cfg, is_addr;

    // Entry i's address is also frozen when entry i+1 is a locked TOR range,
    // since pmpaddr[i] forms that range's base.
    logic [N_ENTRIES-1:0] next_tor_lock;

    assign idx     = csr_addr[3:0];
    assign is_cfg  = (csr_addr[11:4] == 8'h3A) && (int'(idx) < N_ENTRIES / 4);
    assign is_addr = (csr_addr[11:4] == 8'h3B) && (int'(idx) < N_ENTRIES);

    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_tor
        if (g < N_ENTRIES - 1) begin : g_mid
            assign next_tor_lock[g] = cfg_q[g+1][7] && (cfg_q[g+1][4:3] == A_TOR);
        end else begin : g_last
            assign next_tor_lock[g] = 1'b0;
        end
    end

    // WARL legalisation: R=0,W=1 is reserved so W is dropped; [6:5] read as 0.
    function automatic logic [7:0] warl_cfg(input logic [7:0] w);
        return {w[7], 2'b00, w[4:3], w[2], w[1] & w[0], w[0]};
    endfunction

    always_comb begin
        changed = 1'b0;
        rdata_d = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            cfg_d[i]  = cfg_q[i];
            addr_d[i] = addr_q[i];
            if (csr_we && is_cfg && (i / 4 == int'(idx)) && !cfg_q[i][7]) begin
                cfg_d[i] = warl_cfg(csr_wdata[8*(i%4) +: 8]);
            end
            if (csr_we && is_addr && (i == int'(idx)) &&
                !cfg_q[i][7] && !next_tor_lock[i]) begin
                addr_d[i] = csr_wdata;
            end
            if ((cfg_d[i] != cfg_q[i]) || (addr_d[i] != addr_q[i])) begin
                changed = 1'b1;
            end
            // Read mux sees pre-write state, so a same-cycle write is not visible.
            if (is_cfg && (i / 4 == int'(idx))) begin
                rdata_d[8*(i%4) +: 8] = cfg_q[i];
            end
            if (is_addr && (i == int'(idx))) begin
                rdata_d = addr_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            illegal_q <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                cfg_q[i]  <= cfg_d[i];
                addr_q[i] <= addr_d[i];
            end
            rdata_q   <= csr_re ? rdata_d : '0;
            rvalid_q  <= csr_re;
            illegal_q <= (csr_we || csr_re) && !(is_cfg || is_addr);
            update_q  <= changed;
        end
    end

    assign csr_rdata   = rdata_q;
    assign csr_rvalid  = rvalid_q;
    assign csr_illegal = illegal_q;
    assign pmp_update  = update_q;

    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_out
        assign pmp_addr_o[XLEN*g +: XLEN] = addr_q[g];
        if (g == 0) begin : g_base
            assign pmp_addr_prev_o[XLEN-1:0] = '0;
        end else begin : g_prev
            assign pmp_addr_prev_o[XLEN*g +: XLEN] = addr_q[g-1];
        end
        assign pmp_a_o[2*g +: 2] = cfg_q[g][4:3];
        assign pmp_r_o[g]        = cfg_q[g][0];
        assign pmp_w_o[g]        = cfg_q[g][1];
        assign pmp_x_o[g]        = cfg_q[g][2];
        assign pmp_l_o[g]        = cfg_q[g][7];
    end

endmodule

// File: tb/tb_pmp_csr_regs.sv
// tb/tb_pmp_csr_regs.sv - self-checking bench for pmp_csr_regs

module tb_pmp_csr_regs;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          csr_we, csr_re;
    logic [11:0]   csr_addr;
    logic [31:0]   csr_wdata;
    logic [31:0]   csr_rdata;
    logic          csr_rvalid, csr_illegal, pmp_update;
    logic [32*N-1:0] pmp_addr_o, pmp_addr_prev_o;
    logic [2*N-1:0]  pmp_a_o;
    logic [N-1:0]    pmp_r_o, pmp_w_o, pmp_x_o, pmp_l_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: plain byte/word arrays indexed by entry number.
    logic [7:0]  m_cfg  [N];
    logic [31:0] m_addr [N];

    pmp_csr_regs #(.N_ENTRIES(N), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .csr_we(csr_we), .csr_re(csr_re), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid), .csr_illegal(csr_illegal),
        .pmp_update(pmp_update),
        .pmp_addr_o(pmp_addr_o), .pmp_addr_prev_o(pmp_addr_prev_o), .pmp_a_o(pmp_a_o),
        .pmp_r_o(pmp_r_o), .pmp_w_o(pmp_w_o), .pmp_x_o(pmp_x_o), .pmp_l_o(pmp_l_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [32*N-1:0] ea, ep;
        logic [2*N-1:0]  e_a;
        logic [N-1:0]    er, ew, ex, el;
        for (int i = 0; i < N; i++) begin
            ea[32*i +: 32] = m_addr[i];
            ep[32*i +: 32] = (i == 0) ? 32'h0 : m_addr[i-1];
            e_a[2*i +: 2]  = m_cfg[i][4:3];
            er[i] = m_cfg[i][0];
            ew[i] = m_cfg[i][1];
            ex[i] = m_cfg[i][2];
            el[i] = m_cfg[i][7];
        end
        chk({tag, ".addr"}, pmp_addr_o, ea);
        chk({tag, ".prev"}, pmp_addr_prev_o, ep);
        chk({tag, ".a"}, pmp_a_o, e_a);
        chk({tag, ".rwxl"}, {pmp_r_o, pmp_w_o, pmp_x_o, pmp_l_o}, {er, ew, ex, el});
    endtask

    function automatic bit is_locked_addr(input int i);
        if (m_cfg[i][7]) return 1'b1;
        if (i + 1 < N && m_cfg[i+1][7] && m_cfg[i+1][4:3] == 2'd1) return 1'b1;
        return 1'b0;
    endfunction

    // One CSR access: predict from the model, apply, then compare one cycle later.
    task automatic op(input logic we, input logic re, input logic [11:0] a,
                      input logic [31:0] wd, input string tag);
        logic [31:0] e_rd;
        logic        e_ill, e_upd;
        bit          is_c, is_a;
        int          k;
        logic [7:0]  b;
        is_c  = (a >= 12'h3A0) && (a < 12'h3A0 + N / 4);
        is_a  = (a >= 12'h3B0) && (a < 12'h3B0 + N);
        e_rd  = 32'h0;
        e_upd = 1'b0;
        e_ill = (we || re) && !is_c && !is_a;
        if (is_c) begin
            k = int'(a - 12'h3A0);
            e_rd = {m_cfg[4*k+3], m_cfg[4*k+2], m_cfg[4*k+1], m_cfg[4*k]};
        end
        if (is_a) e_rd = m_addr[int'(a - 12'h3B0)];
        if (we && is_c) begin
            k = int'(a - 12'h3A0);
            for (int j = 0; j < 4; j++) begin
                if (!m_cfg[4*k+j][7]) begin
                    b = wd[8*j +: 8];
                    b[6:5] = 2'b00;
                    if (b[1:0] == 2'b10) b[1] = 1'b0;
                    if (b != m_cfg[4*k+j]) e_upd = 1'b1;
                    m_cfg[4*k+j] = b;
                end
            end
        end
        if (we && is_a) begin
            k = int'(a - 12'h3B0);
            if (!is_locked_addr(k)) begin
                if (m_addr[k] != wd) e_upd = 1'b1;
                m_addr[k] = wd;
            end
        end
        @(negedge clk);
        csr_we = we; csr_re = re; csr_addr = a; csr_wdata = wd;
        @(posedge clk);
        #1;
        csr_we = 1'b0; csr_re = 1'b0;
        chk({tag, ".rvalid"}, csr_rvalid, re);
        if (re) chk({tag, ".rdata"}, csr_rdata, e_rd);
        chk({tag, ".illegal"}, csr_illegal, e_ill);
        chk({tag, ".update"}, pmp_update, e_upd);
        check_state(tag);
    endtask

    // Reset with a concurrent write: reset must win.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; csr_we = 1'b1; csr_re = 1'b0; csr_addr = 12'h3B0; csr_wdata = $urandom;
        @(posedge clk);
        #1;
        rst = 1'b0; csr_we = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_cfg[i] = 8'h0;
            m_addr[i] = 32'h0;
        end
        chk({tag, ".rvalid"}, csr_rvalid, 1'b0);
        chk({tag, ".rdata"}, csr_rdata, 32'h0);
        chk({tag, ".illegal"}, csr_illegal, 1'b0);
        chk({tag, ".update"}, pmp_update, 1'b0);
        check_state(tag);
    endtask

    initial begin
        logic [11:0] a;
        logic [31:0] wd;
        int          sel;
        rst = 1'b1; csr_we = 1'b0; csr_re = 1'b0; csr_addr = '0; csr_wdata = '0;
        repeat (2) @(posedge clk);
        do_reset("t1.rst");
        op(0, 1, 12'h3A0, 32'h0, "t1.rd3A0");
        op(0, 1, 12'h3B5, 32'h0, "t1.rd3B5");
        op(0, 0, 12'h000, 32'h0, "t1.idle");

        op(1, 0, 12'h3B2, 32'h0000_1000, "t2.wraddr2");
        op(1, 0, 12'h3A0, 32'h0018_0000, "t2.wrcfg0");
        chk("t2.a2_napot", pmp_a_o[5:4], 2'b11);
        chk("t2.addr2", pmp_addr_o[95:64], 32'h1000);
        op(0, 0, 12'h000, 32'h0, "t2.idle");

        op(1, 0, 12'h3A0, 32'h0018_8F00, "t3.lock1");
        op(1, 0, 12'h3B1, 32'h0000_FFFF, "t3.wraddr1");
        op(1, 0, 12'h3B0, 32'h0000_0055, "t3.wraddr0");
        op(1, 0, 12'h3A0, 32'h0018_0000, "t3.wrcfg_locked");
        chk("t3.l1", pmp_l_o[1], 1'b1);
        do_reset("t3.rst");
        chk("t3.l1_clr", pmp_l_o[1], 1'b0);

        op(1, 0, 12'h3A0, 32'h0000_0002, "t4.warl");
        op(0, 1, 12'h3A0, 32'h0, "t4.rd");
        chk("t4.w0", pmp_w_o[0], 1'b0);

        op(1, 1, 12'h3B3, 32'h0000_ABCD, "t5.rw");
        op(0, 1, 12'h3B3, 32'h0, "t5.rd");

        op(0, 1, 12'h3C0, 32'h0, "t6.rd");
        op(1, 0, 12'h3C0, 32'hDEAD_BEEF, "t6.wr");
        op(1, 0, 12'h3A4, 32'hFFFF_FFFF, "t6.wr3A4");

        for (int it = 0; it < 400; it++) begin
            if (it % 80 == 79) do_reset("rnd.rst");
            sel = $urandom_range(0, 9);
            if (sel < 3)      a = 12'h3A0 + 12'($urandom_range(0, 3));
            else if (sel < 8) a = 12'h3B0 + 12'($urandom_range(0, 15));
            else if (sel < 9) a = 12'h3A4 + 12'($urandom_range(0, 11));
            else              a = 12'($urandom_range(0, 4095));
            wd = $urandom;
            if (sel < 3 && $urandom_range(0, 7) != 0) wd = wd & 32'h7F7F_7F7F;
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, wd, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
